// File: rtl/zero_run_event_monitor.sv
// Turns the upstream zero-run flag into rising-edge events, keeps total/per-window counts,
// and raises a sticky alarm when one fixed window collects at least THRESH events.
module zero_run_event_monitor #(
  parameter int CNT_W  = 8,
  parameter int THRESH = 3,
  parameter int WINDOW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             z_in,
  output logic             event_pulse,
  output logic [CNT_W-1:0] event_cnt,
  output logic [CNT_W-1:0] win_cnt,
  output logic             alarm
);

  localparam int TW = $clog2(WINDOW);

  typedef enum logic [1:0] {IDLE, COUNT, ALARM} state_t;

  state_t           state;
  logic             z_prev;
  logic [TW-1:0]    timer;
  logic             ev;
  logic             last;
  logic [CNT_W-1:0] cnt_max;
  logic [CNT_W-1:0] win_next;

  always_comb begin
    cnt_max  = '1;
    ev       = z_in & ~z_prev & (state != IDLE) & ~clr;
    last     = (timer == TW'(WINDOW - 1));
    win_next = (ev && win_cnt != cnt_max) ? win_cnt + CNT_W'(1) : win_cnt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      z_prev      <= 1'b0;
      timer       <= '0;
      event_pulse <= 1'b0;
      event_cnt   <= '0;
      win_cnt     <= '0;
      alarm       <= 1'b0;
    end else begin
      z_prev      <= z_in;
      event_pulse <= ev;
      if (clr) begin
        event_cnt <= '0;
        win_cnt   <= '0;
        timer     <= '0;
        alarm     <= 1'b0;
        state     <= en ? COUNT : IDLE;
      end else begin
        // Total count runs in COUNT and ALARM alike, and survives en dropping.
        if (ev && event_cnt != cnt_max)
          event_cnt <= event_cnt + CNT_W'(1);
        case (state)
          IDLE: begin
            timer   <= '0;
            win_cnt <= '0;
            if (en)
              state <= COUNT;
          end
          COUNT: begin
            if (last && win_next >= CNT_W'(THRESH)) begin
              // Timer stays frozen and win_cnt keeps the tripping value.
              state   <= ALARM;
              alarm   <= 1'b1;
              win_cnt <= win_next;
            end else if (!en) begin
              state   <= IDLE;
              timer   <= '0;
              win_cnt <= '0;
            end else if (last) begin
              timer   <= '0;
              win_cnt <= '0;
            end else begin
              timer   <= timer + TW'(1);
              win_cnt <= win_next;
            end
          end
          ALARM: begin
            alarm <= 1'b1;
          end
          default: begin
            state <= IDLE;
            alarm <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
